add_sub_rs: RTL and testbench
=============================

ADD_SUB_RS -- requirements
Module: add_sub_rs

Interface
- REQ-001 Parameter RS_ID_WIDTH, default 5: global tag width, used for rs_id and producer tags.
- REQ-002 Parameter ENTRIES, default 4: number of entries, range 2..8.
- REQ-003 Parameter RS_BASE_ID, default 0: tag of entry 0; entry i owns tag RS_BASE_ID+i.
- REQ-004 Port clk, input, 1: single clock, rising edge; the block SHALL use one clock; reset is asynchronous and active-high.
- REQ-005 Port rst, input, 1: asynchronous active-high reset.
- REQ-006 dispatch_valid in 1, dispatch_ready out 1: dispatch handshake.
- REQ-007 disp_op1/disp_op2 in 32 each; disp_op1_valid/disp_op2_valid in 1; disp_op1_tag/disp_op2_tag in RS_ID_WIDTH: value, or producer tag when not valid.
- REQ-008 disp_ca in 1, disp_ca_valid in 1, disp_ca_tag in RS_ID_WIDTH: carry operand (XER.CA), same value-or-tag rule.
- REQ-009 disp_control in add_sub_decode_t; disp_result_reg_addr in 5.
- REQ-010 cdb_valid in 1, cdb_tag in RS_ID_WIDTH, cdb_data in 32, cdb_ca in 1, cdb_ca_valid in 1: result broadcast snoop.
- REQ-011 issue_valid out 1, issue_ready in 1, rs_id_out out RS_ID_WIDTH, result_reg_addr_out out 5, op1/op2 out 32, carry_in out 1, control out add_sub_decode_t: issue to the add/sub unit.

Function
- REQ-012 Each entry holds busy, three operand slots (value, valid, tag), control, result register address and an age value.
- REQ-013 dispatch_ready SHALL be 1 iff at least one entry is not busy, from registered state only; no combinational path from issue_ready to dispatch_ready.
- REQ-014 On a dispatch handshake, the lowest-index free entry is written and set busy on the next edge.
- REQ-015 Each cycle with cdb_valid=1, every busy, not-valid op1/op2 slot whose tag equals cdb_tag captures cdb_data and sets valid.
- REQ-016 The carry slot captures cdb_ca only when cdb_ca_valid=1 and its tag matches.
- REQ-017 A dispatch in the same cycle as a matching CDB broadcast captures the CDB value into the new entry (bypass); the operand is not lost.
- REQ-018 An entry is ready when busy and all three slots are valid, using registered state; minimum dispatch-to-issue_valid latency is 1 cycle, CDB-capture-to-ready is 1 cycle.
- REQ-019 issue_valid=1 iff any entry is ready; issue outputs are driven from the selected entry; rs_id_out = RS_BASE_ID + index.
- REQ-020 Once issue_valid=1 with issue_ready=0, the selected entry and outputs SHALL stay stable until the handshake.
- REQ-021 On an issue handshake, the entry clears busy at the edge; that entry is not reusable by a dispatch in the same cycle.
- REQ-022 Simultaneous dispatch and issue are both accepted when dispatch_ready=1.
- REQ-023 When all ENTRIES are busy, dispatch_ready=0; when none are busy, issue_valid=0.
- REQ-024 Tag comparison covers the full RS_ID_WIDTH bits; the age counter saturates at ENTRIES-1 and does not wrap.

Reset
- REQ-025 While rst=1 all entries are cleared asynchronously: busy=0, slots valid=0, values, tags and ages 0.
- REQ-026 Reset values: issue_valid=0, dispatch_ready=1, rs_id_out=0, op1/op2=0, carry_in=0, control=0, result_reg_addr_out=0.
- REQ-027 Reset mid-operation discards all held instructions; no issue occurs after rst is released until a new dispatch.

Configuration
- REQ-028 Macro ADD_SUB_RS_AGE_PRIORITY_EN defined: among ready entries, the oldest (the one dispatched earliest) is selected; an age is set 0 on dispatch, incremented for other busy entries on each dispatch, and aged relative to freed entries.
- REQ-029 Macro undefined: the lowest-index ready entry is selected; age logic is not synthesised.

Verification
- REQ-030 Dispatch op1=5, op2=3, carry valid, all operands valid, issue_ready=1 -> issue_valid the next cycle with op1=5, op2=3, rs_id_out=RS_BASE_ID; entry free after.
- REQ-031 Dispatch op1 waiting on tag 9; then cdb_valid, tag 9, data 0x1234 -> issue_valid one cycle later with op1=0x1234.
- REQ-032 Dispatch with op2 waiting on tag 7 while cdb tag 7, data 0xFFFFFFFF in the same cycle -> entry issues with op2=0xFFFFFFFF, no hang.
- REQ-033 Fill 4 entries with issue_ready=0 -> dispatch_ready=0 and outputs stable; raise issue_ready for 1 cycle -> dispatch_ready=1 the next cycle.
- REQ-034 With the macro: dispatch A into entry 2, then B into entry 0, both ready -> A issues first; without the macro B issues first.
- REQ-035 Assert rst with 3 busy entries -> issue_valid=0 and dispatch_ready=1 immediately, no stale issue after release.

Source files
------------

// File: rtl/add_sub_rs.sv
// Reservation station for the add/sub unit.
// Holds up to ENTRIES instructions. Each entry waits for op1, op2 and carry (XER.CA) by
// snooping the CDB, then issues to the add/sub unit.
// Optional feature: define ADD_SUB_RS_AGE_PRIORITY_EN to issue the oldest ready entry.
// Without it, the lowest-index ready entry issues and no age state is built.
// control/disp_control carry the packed add_sub_decode_t encoding (CONTROL_WIDTH bits).
module add_sub_rs #(
  parameter int unsigned RS_ID_WIDTH   = 5,
  parameter int unsigned ENTRIES       = 4,
  parameter int unsigned RS_BASE_ID    = 0,
  parameter int unsigned CONTROL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  // dispatch
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  logic [31:0]              disp_op1,
  input  logic                     disp_op1_valid,
  input  logic [RS_ID_WIDTH-1:0]   disp_op1_tag,
  input  logic [31:0]              disp_op2,
  input  logic                     disp_op2_valid,
  input  logic [RS_ID_WIDTH-1:0]   disp_op2_tag,
  input  logic                     disp_ca,
  input  logic                     disp_ca_valid,
  input  logic [RS_ID_WIDTH-1:0]   disp_ca_tag,
  input  logic [CONTROL_WIDTH-1:0] disp_control,
  input  logic [4:0]               disp_result_reg_addr,
  // result broadcast
  input  logic                     cdb_valid,
  input  logic [RS_ID_WIDTH-1:0]   cdb_tag,
  input  logic [31:0]              cdb_data,
  input  logic                     cdb_ca,
  input  logic                     cdb_ca_valid,
  // issue
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [RS_ID_WIDTH-1:0]   rs_id_out,
  output logic [4:0]               result_reg_addr_out,
  output logic [31:0]              op1,
  output logic [31:0]              op2,
  output logic                     carry_in,
  output logic [CONTROL_WIDTH-1:0] control
);

  localparam int unsigned IdxW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  typedef logic [IdxW-1:0] idx_t;

  logic [ENTRIES-1:0]       busy_q, busy_d;
  logic [ENTRIES-1:0]       op1_v_q, op1_v_d, op2_v_q, op2_v_d, ca_v_q, ca_v_d;
  logic [ENTRIES-1:0]       ca_q, ca_d;
  logic [31:0]              op1_q [ENTRIES];
  logic [31:0]              op1_d [ENTRIES];
  logic [31:0]              op2_q [ENTRIES];
  logic [31:0]              op2_d [ENTRIES];
  logic [RS_ID_WIDTH-1:0]   op1_tag_q [ENTRIES];
  logic [RS_ID_WIDTH-1:0]   op1_tag_d [ENTRIES];
  logic [RS_ID_WIDTH-1:0]   op2_tag_q [ENTRIES];
  logic [RS_ID_WIDTH-1:0]   op2_tag_d [ENTRIES];
  logic [RS_ID_WIDTH-1:0]   ca_tag_q [ENTRIES];
  logic [RS_ID_WIDTH-1:0]   ca_tag_d [ENTRIES];
  logic [CONTROL_WIDTH-1:0] ctrl_q [ENTRIES];
  logic [CONTROL_WIDTH-1:0] ctrl_d [ENTRIES];
  logic [4:0]               rd_q [ENTRIES];
  logic [4:0]               rd_d [ENTRIES];

  // Selection lock keeps a stalled issue stable even if a lower-priority entry becomes ready.
  logic lock_q, lock_d;
  idx_t lock_idx_q, lock_idx_d;

  logic [ENTRIES-1:0] ready;
  logic               any_ready;
  logic               free_found;
  idx_t               free_idx;
  logic               pick_found;
  idx_t               pick_idx;
  idx_t               sel_idx;
  logic               issue_fire;
  logic               disp_fire;
  logic               byp1, byp2, bypc;

  assign ready      = busy_q & op1_v_q & op2_v_q & ca_v_q;
  assign any_ready  = |ready;
  assign sel_idx    = lock_q ? lock_idx_q : pick_idx;
  assign issue_fire = any_ready & issue_ready;
  assign disp_fire  = dispatch_valid & free_found;
  assign byp1       = cdb_valid && (cdb_tag == disp_op1_tag);
  assign byp2       = cdb_valid && (cdb_tag == disp_op2_tag);
  assign bypc       = cdb_valid && cdb_ca_valid && (cdb_tag == disp_ca_tag);

  // Lowest-index free entry; dispatch_ready comes from registered busy bits only.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_idx   = idx_t'(i);
        free_found = 1'b1;
      end
    end
  end

  assign dispatch_ready = free_found;

`ifdef ADD_SUB_RS_AGE_PRIORITY_EN
  localparam idx_t AgeMax = idx_t'(ENTRIES - 1);

  // Age = number of younger busy entries, so the oldest entry has the largest age.
  idx_t age_q [ENTRIES];
  idx_t age_d [ENTRIES];
  idx_t best_age;

  // Pick the oldest ready entry; ties go to the lowest index.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    best_age   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (ready[i] && (!pick_found || (age_q[i] > best_age))) begin
        pick_idx   = idx_t'(i);
        best_age   = age_q[i];
        pick_found = 1'b1;
      end
    end
  end

  // Age update: issuing an entry makes everything older one step younger; dispatch ages others.
  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      age_d[i] = age_q[i];
      if (!busy_q[i] || (issue_fire && (sel_idx == idx_t'(i)))) begin
        age_d[i] = '0;
      end else begin
        if (issue_fire && (age_q[i] > age_q[sel_idx])) age_d[i] = age_d[i] - 1'b1;
        if (disp_fire && (age_d[i] != AgeMax)) age_d[i] = age_d[i] + 1'b1;
      end
    end
  end

  // Age registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) age_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) age_q[i] <= age_d[i];
    end
  end
`else
  // Pick the lowest-index ready entry.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (ready[i] && !pick_found) begin
        pick_idx   = idx_t'(i);
        pick_found = 1'b1;
      end
    end
  end
`endif

  // Issue outputs come from the selected entry and are zero while nothing is ready.
  always_comb begin
    issue_valid         = any_ready;
    rs_id_out           = '0;
    result_reg_addr_out = '0;
    op1                 = '0;
    op2                 = '0;
    carry_in            = 1'b0;
    control             = '0;
    if (any_ready) begin
      rs_id_out           = RS_ID_WIDTH'(RS_BASE_ID) + RS_ID_WIDTH'(sel_idx);
      result_reg_addr_out = rd_q[sel_idx];
      op1                 = op1_q[sel_idx];
      op2                 = op2_q[sel_idx];
      carry_in            = ca_q[sel_idx];
      control             = ctrl_q[sel_idx];
    end
  end

  // Entry next state: CDB snoop, issue release, then dispatch write with CDB bypass.
  always_comb begin
    busy_d     = busy_q;
    op1_v_d    = op1_v_q;
    op2_v_d    = op2_v_q;
    ca_v_d     = ca_v_q;
    ca_d       = ca_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    op1_tag_d  = op1_tag_q;
    op2_tag_d  = op2_tag_q;
    ca_tag_d   = ca_tag_q;
    ctrl_d     = ctrl_q;
    rd_d       = rd_q;
    lock_d     = any_ready & ~issue_ready;
    lock_idx_d = sel_idx;

    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (busy_q[i] && cdb_valid) begin
        if (!op1_v_q[i] && (cdb_tag == op1_tag_q[i])) begin
          op1_d[i]   = cdb_data;
          op1_v_d[i] = 1'b1;
        end
        if (!op2_v_q[i] && (cdb_tag == op2_tag_q[i])) begin
          op2_d[i]   = cdb_data;
          op2_v_d[i] = 1'b1;
        end
        if (!ca_v_q[i] && cdb_ca_valid && (cdb_tag == ca_tag_q[i])) begin
          ca_d[i]   = cdb_ca;
          ca_v_d[i] = 1'b1;
        end
      end
    end

    if (issue_fire) begin
      busy_d[sel_idx] = 1'b0;
    end

    // The free entry is never the issuing one, so both handshakes can land together.
    if (disp_fire) begin
      busy_d[free_idx]    = 1'b1;
      op1_v_d[free_idx]   = disp_op1_valid | byp1;
      op1_d[free_idx]     = (!disp_op1_valid && byp1) ? cdb_data : disp_op1;
      op1_tag_d[free_idx] = disp_op1_tag;
      op2_v_d[free_idx]   = disp_op2_valid | byp2;
      op2_d[free_idx]     = (!disp_op2_valid && byp2) ? cdb_data : disp_op2;
      op2_tag_d[free_idx] = disp_op2_tag;
      ca_v_d[free_idx]    = disp_ca_valid | bypc;
      ca_d[free_idx]      = (!disp_ca_valid && bypc) ? cdb_ca : disp_ca;
      ca_tag_d[free_idx]  = disp_ca_tag;
      ctrl_d[free_idx]    = disp_control;
      rd_d[free_idx]      = disp_result_reg_addr;
    end
  end

  // Entry and lock registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      op1_v_q    <= '0;
      op2_v_q    <= '0;
      ca_v_q     <= '0;
      ca_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        op1_q[i]     <= '0;
        op2_q[i]     <= '0;
        op1_tag_q[i] <= '0;
        op2_tag_q[i] <= '0;
        ca_tag_q[i]  <= '0;
        ctrl_q[i]    <= '0;
        rd_q[i]      <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      op1_v_q    <= op1_v_d;
      op2_v_q    <= op2_v_d;
      ca_v_q     <= ca_v_d;
      ca_q       <= ca_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        op1_q[i]     <= op1_d[i];
        op2_q[i]     <= op2_d[i];
        op1_tag_q[i] <= op1_tag_d[i];
        op2_tag_q[i] <= op2_tag_d[i];
        ca_tag_q[i]  <= ca_tag_d[i];
        ctrl_q[i]    <= ctrl_d[i];
        rd_q[i]      <= rd_d[i];
      end
    end
  end

endmodule

// File: tb/tb_add_sub_rs.sv
// Bench for add_sub_rs: table of single-instruction vectors plus hand-written sequences
// (bypass, full station, issue ordering, reset mid-operation). Issued instructions are
// checked against a scoreboard queue filled when stimulus is driven.
module tb_add_sub_rs;
  localparam int unsigned RsIdW = 5;
  localparam int unsigned Entries = 4;
  localparam int unsigned CtrlW = 8;

  logic             clk, rst;
  logic             dispatch_valid, dispatch_ready;
  logic [31:0]      disp_op1, disp_op2;
  logic             disp_op1_valid, disp_op2_valid;
  logic [RsIdW-1:0] disp_op1_tag, disp_op2_tag;
  logic             disp_ca, disp_ca_valid;
  logic [RsIdW-1:0] disp_ca_tag;
  logic [CtrlW-1:0] disp_control;
  logic [4:0]       disp_result_reg_addr;
  logic             cdb_valid;
  logic [RsIdW-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_ca, cdb_ca_valid;
  logic             issue_valid, issue_ready;
  logic [RsIdW-1:0] rs_id_out;
  logic [4:0]       result_reg_addr_out;
  logic [31:0]      op1, op2;
  logic             carry_in;
  logic [CtrlW-1:0] control;

  add_sub_rs #(
    .RS_ID_WIDTH  (RsIdW),
    .ENTRIES      (Entries),
    .RS_BASE_ID   (0),
    .CONTROL_WIDTH(CtrlW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .dispatch_valid      (dispatch_valid),
    .dispatch_ready      (dispatch_ready),
    .disp_op1            (disp_op1),
    .disp_op1_valid      (disp_op1_valid),
    .disp_op1_tag        (disp_op1_tag),
    .disp_op2            (disp_op2),
    .disp_op2_valid      (disp_op2_valid),
    .disp_op2_tag        (disp_op2_tag),
    .disp_ca             (disp_ca),
    .disp_ca_valid       (disp_ca_valid),
    .disp_ca_tag         (disp_ca_tag),
    .disp_control        (disp_control),
    .disp_result_reg_addr(disp_result_reg_addr),
    .cdb_valid           (cdb_valid),
    .cdb_tag             (cdb_tag),
    .cdb_data            (cdb_data),
    .cdb_ca              (cdb_ca),
    .cdb_ca_valid        (cdb_ca_valid),
    .issue_valid         (issue_valid),
    .issue_ready         (issue_ready),
    .rs_id_out           (rs_id_out),
    .result_reg_addr_out (result_reg_addr_out),
    .op1                 (op1),
    .op2                 (op2),
    .carry_in            (carry_in),
    .control             (control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic             ca;
    logic [CtrlW-1:0] ctrl;
    logic [4:0]       rd;
    logic [RsIdW-1:0] rs_id;
  } iss_t;

  // pend: 0 none, 1 op1, 2 op2, 3 carry waits on tag
  typedef struct {
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic             ca;
    logic [CtrlW-1:0] ctrl;
    logic [4:0]       rd;
    int               pend;
    logic [RsIdW-1:0] tag;
    logic [31:0]      cdata;
    logic             cca;
    logic [31:0]      eop1;
    logic [31:0]      eop2;
    logic             eca;
  } vec_t;

  iss_t sb[$];
  iss_t mon_exp;
  int   n_vec = 0;
  int   n_err = 0;

  // Scoreboard check on every issue handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got rs_id=%0d op1=%h op2=%h, required no issue",
                 rs_id_out, op1, op2);
      end else begin
        mon_exp = sb.pop_front();
        if (rs_id_out !== mon_exp.rs_id || op1 !== mon_exp.op1 || op2 !== mon_exp.op2 ||
            carry_in !== mon_exp.ca || control !== mon_exp.ctrl ||
            result_reg_addr_out !== mon_exp.rd) begin
          n_err++;
          $display("FAIL issue_data: got id=%0d op1=%h op2=%h ca=%b ctl=%h rd=%0d, required id=%0d op1=%h op2=%h ca=%b ctl=%h rd=%0d",
                   rs_id_out, op1, op2, carry_in, control, result_reg_addr_out,
                   mon_exp.rs_id, mon_exp.op1, mon_exp.op2, mon_exp.ca, mon_exp.ctrl, mon_exp.rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] o1, input logic [31:0] o2, input logic ca,
                      input logic [CtrlW-1:0] ctl, input logic [4:0] rd,
                      input logic [RsIdW-1:0] id);
    iss_t e;
    e.op1 = o1; e.op2 = o2; e.ca = ca; e.ctrl = ctl; e.rd = rd; e.rs_id = id;
    sb.push_back(e);
  endtask

  // One-cycle dispatch; any CDB value set by the caller is dropped afterwards.
  task automatic disp(input logic [31:0] o1, input logic v1, input logic [RsIdW-1:0] t1,
                      input logic [31:0] o2, input logic v2, input logic [RsIdW-1:0] t2,
                      input logic ca, input logic cav, input logic [RsIdW-1:0] cat,
                      input logic [CtrlW-1:0] ctl, input logic [4:0] rd);
    disp_op1 = o1; disp_op1_valid = v1; disp_op1_tag = t1;
    disp_op2 = o2; disp_op2_valid = v2; disp_op2_tag = t2;
    disp_ca = ca; disp_ca_valid = cav; disp_ca_tag = cat;
    disp_control = ctl; disp_result_reg_addr = rd;
    dispatch_valid = 1'b1;
    step();
    dispatch_valid = 1'b0;
    cdb_valid = 1'b0;
    cdb_ca_valid = 1'b0;
  endtask

  task automatic cdb(input logic [RsIdW-1:0] tag, input logic [31:0] d, input logic ca,
                     input logic cav);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = d; cdb_ca = ca; cdb_ca_valid = cav;
    step();
    cdb_valid = 1'b0;
    cdb_ca_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      step();
      k++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s: got %0d instructions still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  vec_t tbl[6];
  logic [RsIdW-1:0] first_id;

  initial begin
    tbl[0] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 8'h01, 5'd1, 0, 5'd0, 32'h0, 1'b0,
               32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0};
    tbl[1] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 8'h82, 5'd31, 0, 5'd0, 32'h0, 1'b0,
               32'h00000000, 32'hFFFFFFFF, 1'b1};
    tbl[2] = '{32'h0, 32'h00000042, 1'b0, 8'h03, 5'd7, 1, 5'd9, 32'h00001234, 1'b0,
               32'h00001234, 32'h00000042, 1'b0};
    tbl[3] = '{32'h11111111, 32'h0, 1'b1, 8'h04, 5'd12, 2, 5'd31, 32'hDEADBEEF, 1'b0,
               32'h11111111, 32'hDEADBEEF, 1'b1};
    tbl[4] = '{32'h00000010, 32'h00000020, 1'b0, 8'h05, 5'd2, 3, 5'd3, 32'h0, 1'b1,
               32'h00000010, 32'h00000020, 1'b1};
    tbl[5] = '{32'h00000077, 32'h00000099, 1'b0, 8'hF0, 5'd20, 1, 5'd16, 32'h00000000, 1'b0,
               32'h00000000, 32'h00000099, 1'b0};

    rst = 1'b1; issue_ready = 1'b0; dispatch_valid = 1'b0;
    disp_op1 = '0; disp_op1_valid = 1'b0; disp_op1_tag = '0;
    disp_op2 = '0; disp_op2_valid = 1'b0; disp_op2_tag = '0;
    disp_ca = 1'b0; disp_ca_valid = 1'b0; disp_ca_tag = '0;
    disp_control = '0; disp_result_reg_addr = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_ca = 1'b0; cdb_ca_valid = 1'b0;
    repeat (2) step();
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    chk("rst_rs_id", 32'(rs_id_out), 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_op2", op2, 32'd0);
    chk("rst_carry", 32'(carry_in), 32'd0);
    chk("rst_control", 32'(control), 32'd0);
    chk("rst_rd", 32'(result_reg_addr_out), 32'd0);
    rst = 1'b0;
    step();

    // Simple all-valid dispatch issues the next cycle from entry 0.
    issue_ready = 1'b1;
    push(32'd5, 32'd3, 1'b1, 8'h11, 5'd3, 5'd0);
    disp(32'd5, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 8'h11, 5'd3);
    chk("basic_issue_valid", 32'(issue_valid), 32'd1);
    chk("basic_op1", op1, 32'd5);
    chk("basic_op2", op2, 32'd3);
    chk("basic_rs_id", 32'(rs_id_out), 32'd0);
    step();
    chk("basic_freed_valid", 32'(issue_valid), 32'd0);
    chk("basic_freed_ready", 32'(dispatch_ready), 32'd1);

    // Table: one instruction at a time, optionally waiting on one CDB tag.
    for (int v = 0; v < 6; v++) begin
      push(tbl[v].eop1, tbl[v].eop2, tbl[v].eca, tbl[v].ctrl, tbl[v].rd, 5'd0);
      disp(tbl[v].op1, tbl[v].pend != 1, tbl[v].tag, tbl[v].op2, tbl[v].pend != 2, tbl[v].tag,
           tbl[v].ca, tbl[v].pend != 3, tbl[v].tag, tbl[v].ctrl, tbl[v].rd);
      if (tbl[v].pend != 0) begin
        chk($sformatf("tbl%0d_wait", v), 32'(issue_valid), 32'd0);
        // Tag differing only in the MSB must not match.
        cdb(tbl[v].tag ^ 5'h10, ~tbl[v].cdata, ~tbl[v].cca, 1'b1);
        chk($sformatf("tbl%0d_msb_tag", v), 32'(issue_valid), 32'd0);
        if (tbl[v].pend == 3) begin
          cdb(tbl[v].tag, 32'h0, ~tbl[v].cca, 1'b0);
          chk($sformatf("tbl%0d_ca_gate", v), 32'(issue_valid), 32'd0);
        end
        cdb(tbl[v].tag, tbl[v].cdata, tbl[v].cca, 1'b1);
        chk($sformatf("tbl%0d_ready", v), 32'(issue_valid), 32'd1);
      end
      drain($sformatf("tbl%0d_drain", v), 5);
    end

    // Dispatch and matching broadcast in the same cycle: value bypasses into the entry.
    push(32'd10, 32'hFFFFFFFF, 1'b0, 8'h22, 5'd4, 5'd0);
    cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_data = 32'hFFFFFFFF; cdb_ca = 1'b0;
    cdb_ca_valid = 1'b0;
    disp(32'd10, 1'b1, 5'd0, 32'd0, 1'b0, 5'd7, 1'b0, 1'b1, 5'd0, 8'h22, 5'd4);
    chk("bypass_valid", 32'(issue_valid), 32'd1);
    chk("bypass_op2", op2, 32'hFFFFFFFF);
    drain("bypass_drain", 5);

    // Fill the station with issue stalled, then release one issue.
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill%0d_ready", k), 32'(dispatch_ready), 32'd1);
      push(32'd100 + 32'(k), 32'd200 + 32'(k), 1'b0, 8'h30, 5'(k), 5'(k));
      disp(32'd100 + 32'(k), 1'b1, 5'd0, 32'd200 + 32'(k), 1'b1, 5'd0, 1'b0, 1'b1, 5'd0,
           8'h30, 5'(k));
    end
    chk("full_dispatch_ready", 32'(dispatch_ready), 32'd0);
    chk("full_issue_valid", 32'(issue_valid), 32'd1);
    // Dispatch attempt while full must be ignored.
    disp(32'd999, 1'b1, 5'd0, 32'd999, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 8'h30, 5'd9);
    repeat (2) step();
    chk("stall_rs_id", 32'(rs_id_out), 32'd0);
    chk("stall_op1", op1, 32'd100);
    chk("stall_ready", 32'(dispatch_ready), 32'd0);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("release_dispatch_ready", 32'(dispatch_ready), 32'd1);
    chk("release_next_id", 32'(rs_id_out), 32'd1);
    issue_ready = 1'b1;
    drain("full_drain", 10);

    // Issue priority: A lands in entry 2, B later in entry 0; both become ready together.
    push(32'h20202020, 32'h100, 1'b0, 8'h40, 5'd10, 5'd0);
    disp(32'h0, 1'b0, 5'd20, 32'h100, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 8'h40, 5'd10);
    disp(32'h0, 1'b0, 5'd21, 32'h101, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 8'h41, 5'd11);
    disp(32'h0, 1'b0, 5'd22, 32'h00A, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 8'h4A, 5'd12);
    chk("prio_waiting", 32'(issue_valid), 32'd0);
    cdb(5'd20, 32'h20202020, 1'b0, 1'b0);
    step();
    chk("prio_p0_gone", 32'(issue_valid), 32'd0);
`ifdef ADD_SUB_RS_AGE_PRIORITY_EN
    first_id = 5'd2;
    push(32'h22222222, 32'h00A, 1'b0, 8'h4A, 5'd12, 5'd2);
    push(32'h22222222, 32'h00B, 1'b0, 8'h4B, 5'd13, 5'd0);
`else
    first_id = 5'd0;
    push(32'h22222222, 32'h00B, 1'b0, 8'h4B, 5'd13, 5'd0);
    push(32'h22222222, 32'h00A, 1'b0, 8'h4A, 5'd12, 5'd2);
`endif
    disp(32'h0, 1'b0, 5'd22, 32'h00B, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 8'h4B, 5'd13);
    cdb(5'd22, 32'h22222222, 1'b0, 1'b0);
    chk("prio_first_id", 32'(rs_id_out), 32'(first_id));
    drain("prio_drain", 5);
    push(32'h21212121, 32'h101, 1'b0, 8'h41, 5'd11, 5'd1);
    cdb(5'd21, 32'h21212121, 1'b0, 1'b0);
    drain("prio_p1_drain", 5);

    // Reset with three busy entries discards them immediately.
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      disp(32'd50 + 32'(k), 1'b1, 5'd0, 32'd60, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 8'h50, 5'd1);
    end
    chk("pre_rst_issue_valid", 32'(issue_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("mid_rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    step();
    rst = 1'b0;
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("post_rst_idle%0d", k), 32'(issue_valid), 32'd0);
    end
    push(32'd77, 32'd88, 1'b1, 8'h66, 5'd6, 5'd0);
    disp(32'd77, 1'b1, 5'd0, 32'd88, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 8'h66, 5'd6);
    drain("post_rst_drain", 5);
    step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
